weight_update: RTL and testbench

WEIGHT_UPDATE -- requirements
Module: weight_update

---
 rtl/weight_update.sv | 187 ++++++++++++++++++
 tb/tb_weight_update.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update.sv
// Stored weight array with a streaming gradient-step pass: w[i] -= (err * x[i]) >> (6 + LR_SHIFT),
// saturated to signed 8 bits, one weight per accepted x beat.
module weight_update #(
  parameter int N        = 4,
  parameter int LR_SHIFT = 3,
  localparam int AW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          start,
  input  logic [7:0]    err,
  input  logic [7:0]    x_in,
  input  logic          x_valid,
  output logic          x_ready,
  output logic          busy,
  output logic          done,
  output logic          sat
);

  localparam int            SHIFT    = 6 + LR_SHIFT;
  localparam logic [AW:0]   N_W      = (AW + 1)'(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [7:0]         weights_r [N];
  logic [AW-1:0]      idx_r;
  logic signed [7:0]  err_r;
  logic               x_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               sat_r;

  logic               accept_s;
  logic               last_s;
  logic               wr_ok_s;
  logic               rd_ok_s;
  logic signed [15:0] prod_s;
  logic signed [15:0] step_s;
  logic signed [15:0] wide_s;
  logic [7:0]         cur_w_s;
  logic [7:0]         new_w_s;
  logic               clamp_s;

  // Saturate a widened weight back into the signed Q1.6 range.
  function automatic logic [7:0] clamp8(input logic signed [15:0] v);
    logic [7:0] r;
    if (v > 16'sd127) begin
      r = 8'h7F;
    end else if (v < -16'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  function automatic logic out_of_range(input logic signed [15:0] v);
    return (v > 16'sd127) || (v < -16'sd128);
  endfunction

  // Beat acceptance, write qualification and the per-beat arithmetic.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    wr_ok_s  = 1'b0;
    cur_w_s  = 8'h00;
    prod_s   = 16'sd0;
    step_s   = 16'sd0;
    wide_s   = 16'sd0;
    new_w_s  = 8'h00;
    clamp_s  = 1'b0;
    if (x_ready_r && x_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    last_s = (idx_r == LAST_IDX);
    if (wr_en && (state_r == S_IDLE) && ({1'b0, wr_addr} < N_W)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    cur_w_s = weights_r[idx_r];
    prod_s  = err_r * $signed(x_in);
    // Arithmetic shift floors toward negative infinity, matching the update rule.
    step_s  = prod_s >>> SHIFT;
    wide_s  = {{8{cur_w_s[7]}}, cur_w_s} - step_s;
    new_w_s = clamp8(wide_s);
    clamp_s = out_of_range(wide_s);
  end

  // Combinational read port; addresses past N-1 read as zero.
  always_comb begin
    rd_data = 8'h00;
    rd_ok_s = ({1'b0, rd_addr} < N_W);
    if (rd_ok_s) begin
      rd_data = weights_r[rd_addr];
    end else begin
      rd_data = 8'h00;
    end
  end

  // Weight storage: pass updates in RUN, host loads only in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        weights_r[i] <= 8'h00;
      end
    end else if (accept_s) begin
      weights_r[idx_r] <= new_w_s;
    end else if (wr_ok_s) begin
      weights_r[wr_addr] <= wr_data;
    end
  end

  // Pass control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      idx_r     <= '0;
      err_r     <= 8'sd0;
      x_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= S_RUN;
            err_r     <= $signed(err);
            idx_r     <= '0;
            sat_r     <= 1'b0;
            x_ready_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            x_ready_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept_s) begin
            if (clamp_s) begin
              sat_r <= 1'b1;
            end
            if (last_s) begin
              state_r   <= S_DONE;
              x_ready_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              idx_r <= idx_r + AW'(1);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          x_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign x_ready = x_ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign sat     = sat_r;

endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update (N=4, LR_SHIFT=3) with hand-computed expected weights.
module tb_weight_update;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       start;
  logic [7:0] err;
  logic [7:0] x_in;
  logic       x_valid;
  logic       x_ready;
  logic       busy;
  logic       done;
  logic       sat;

  int pass_cnt = 0;
  int total_cnt = 0;

  weight_update #(.N(4), .LR_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .err(err), .x_in(x_in),
    .x_valid(x_valid), .x_ready(x_ready), .busy(busy), .done(done), .sat(sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic preload(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
    write_w(2'd0, w0); write_w(2'd1, w1); write_w(2'd2, w2); write_w(2'd3, w3);
  endtask

  task automatic start_pass(input logic [7:0] e);
    start = 1'b1; err = e;
    tick();
    start = 1'b0; err = 8'h00;
  endtask

  task automatic beat(input logic [7:0] x);
    x_valid = 1'b1; x_in = x;
    tick();
    x_valid = 1'b0; x_in = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    preload(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== exp_w[i]) $display("FAIL preload w%0d: got %h expected %h", i, rd_data, exp_w[i]);
      else pass_cnt++;
    end
    rst = 1'b0; #2;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== 8'h00) $display("FAIL reset w%0d: got %h expected 00", i, rd_data);
      else pass_cnt++;
    end
    total_cnt++;
    if ({busy, done, sat, x_ready} !== 4'b0000)
      $display("FAIL reset flags: got %b expected 0000", {busy, done, sat, x_ready});
    else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_w [4];
    exp_w = '{8'h38, 8'h10, 8'h20, 8'hF0};
    preload(8'h40, 8'h10, 8'h20, 8'hF0);
    start_pass(8'h40);
    total_cnt++;
    if ({busy, x_ready, done} !== 3'b110) $display("FAIL basic run flags: got %b expected 110", {busy, x_ready, done});
    else pass_cnt++;
    beat(8'h40); beat(8'h00); beat(8'h00);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic early done: got %b expected 0", done);
    else pass_cnt++;
    beat(8'h00);
    total_cnt++;
    if ({busy, x_ready, done} !== 3'b101) $display("FAIL basic done flags: got %b expected 101", {busy, x_ready, done});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== exp_w[i]) $display("FAIL basic w%0d: got %h expected %h", i, rd_data, exp_w[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sat !== 1'b0) $display("FAIL basic sat: got %b expected 0", sat);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL basic idle flags: got %b expected 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_negative_err();
    preload(8'h00, 8'h00, 8'h00, 8'h00);
    start_pass(8'hC0);
    beat(8'h40); beat(8'h00); beat(8'h00); beat(8'h00);
    rd_addr = 2'd0; #1;
    total_cnt++;
    if (rd_data !== 8'h08) $display("FAIL neg_err w0: got %h expected 08", rd_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_saturation();
    preload(8'h80, 8'h7F, 8'h00, 8'h00);
    start_pass(8'h80);
    beat(8'h80); beat(8'h00); beat(8'h00); beat(8'h00);
    rd_addr = 2'd0; #1;
    total_cnt++;
    if (rd_data !== 8'h80) $display("FAIL satA w0: got %h expected 80", rd_data);
    else pass_cnt++;
    total_cnt++;
    if (sat !== 1'b1) $display("FAIL satA flag: got %b expected 1", sat);
    else pass_cnt++;
    tick();
    start_pass(8'h80);
    total_cnt++;
    if (sat !== 1'b0) $display("FAIL satB clear on start: got %b expected 0", sat);
    else pass_cnt++;
    beat(8'h00); beat(8'h7F);
    rd_addr = 2'd1; #1;
    total_cnt++;
    if (rd_data !== 8'h7F) $display("FAIL satB w1: got %h expected 7F", rd_data);
    else pass_cnt++;
    total_cnt++;
    if (sat !== 1'b1) $display("FAIL satB flag: got %b expected 1", sat);
    else pass_cnt++;
    beat(8'h00); beat(8'h00);
    tick();
    start_pass(8'h00);
    beat(8'h00); beat(8'h00); beat(8'h00); beat(8'h00);
    total_cnt++;
    if ({done, sat} !== 2'b10) $display("FAIL sat cleared next pass: got %b expected 10", {done, sat});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_flow_control();
    logic [7:0] exp_w [4];
    exp_w = '{8'hF8, 8'h11, 8'h1C, 8'h38};
    preload(8'h00, 8'h10, 8'h20, 8'h30);
    start_pass(8'h40);
    beat(8'h40); beat(8'hFF);
    tick();
    rd_addr = 2'd2; #1;
    total_cnt++;
    if ({x_ready, done, rd_data} !== {2'b10, 8'h20})
      $display("FAIL flow gap hold: got %b/%h expected 10/20", {x_ready, done}, rd_data);
    else pass_cnt++;
    start = 1'b1; err = 8'h7F; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h55;
    tick();
    start = 1'b0; err = 8'h00; wr_en = 1'b0;
    tick();
    beat(8'h20);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL flow early done: got %b expected 0", done);
    else pass_cnt++;
    beat(8'hC0);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL flow done after beat4: got %b expected 1", done);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== exp_w[i]) $display("FAIL flow w%0d: got %h expected %h", i, rd_data, exp_w[i]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL flow stray start: got %b expected 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_write_with_start();
    logic [7:0] exp_w [4];
    exp_w = '{8'hF8, 8'hF8, 8'h38, 8'hF8};
    preload(8'h00, 8'h00, 8'h00, 8'h00);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h40;
    start_pass(8'h40);
    wr_en = 1'b0;
    beat(8'h40); beat(8'h40); beat(8'h40); beat(8'h40);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== exp_w[i]) $display("FAIL wr_start w%0d: got %h expected %h", i, rd_data, exp_w[i]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid_pass();
    int done_seen;
    preload(8'h40, 8'h10, 8'h20, 8'h30);
    start_pass(8'h40);
    beat(8'h40); beat(8'h40);
    rst = 1'b0; #2;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      total_cnt++;
      if (rd_data !== 8'h00) $display("FAIL midreset w%0d: got %h expected 00", i, rd_data);
      else pass_cnt++;
    end
    total_cnt++;
    if ({busy, x_ready} !== 2'b00) $display("FAIL midreset flags: got %b expected 00", {busy, x_ready});
    else pass_cnt++;
    rst = 1'b1;
    done_seen = 0;
    x_valid = 1'b1; x_in = 8'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    x_valid = 1'b0;
    total_cnt++;
    if (done_seen !== 0) $display("FAIL midreset done pulses: got %0d expected 0", done_seen);
    else pass_cnt++;
    preload(8'h40, 8'h10, 8'h20, 8'h30);
    start_pass(8'h40);
    beat(8'h40); beat(8'h00); beat(8'h00); beat(8'h00);
    rd_addr = 2'd0; #1;
    total_cnt++;
    if ({done, rd_data} !== {1'b1, 8'h38}) $display("FAIL midreset rerun: got %b/%h expected 1/38", done, rd_data);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; rd_addr = 2'd0;
    start = 1'b0; err = 8'h00; x_in = 8'h00; x_valid = 1'b0;
    #12;
    rst = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_negative_err();
    test_saturation();
    test_flow_control();
    test_write_with_start();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
